// File: rtl/binary_counter_pkg.sv
// Shared helpers for binary_counter: default width, Gray conversion and parameter legality.
package binary_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 32;

    // Callers zero-extend narrower values into MAX_WIDTH and slice the result back down.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic bit params_legal(input int width,
                                        input int unsigned max_count,
                                        input int unsigned reset_value);
        if (width < 1 || width > MAX_WIDTH) begin
            return 1'b0;
        end
        if (width < MAX_WIDTH && max_count > ((32'd1 << width) - 32'd1)) begin
            return 1'b0;
        end
        if (reset_value > max_count) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/binary_counter_tc_cmp.sv
// Constant-match equality comparator producing the terminal-count flag.
module binary_counter_tc_cmp
    import binary_counter_pkg::*;
#(
    parameter int              WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MATCH = '1
) (
    input  logic [WIDTH-1:0] value,
    output logic             tc
);

    logic [WIDTH-1:0] bit_eq;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_eq
            assign bit_eq[gi] = value[gi] ~^ MATCH[gi];
        end
    endgenerate

    assign tc = &bit_eq;

endmodule

// File: rtl/binary_counter.sv
// Free-running modulo-(MAX_COUNT+1) up-counter with tc and wrap flags.
// Optional registered Gray output enabled by defining BINARY_COUNTER_GRAY_EN.
module binary_counter
    import binary_counter_pkg::*;
#(
    parameter int          WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned MAX_COUNT   = (32'd1 << WIDTH) - 32'd1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] binary,
`ifdef BINARY_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] gray,
`endif
    output logic             tc,
    output logic             wrap
);

    generate
        if (!params_legal(WIDTH, MAX_COUNT, RESET_VALUE)) begin : g_bad_params
            $fatal(1, "binary_counter: illegal WIDTH/MAX_COUNT/RESET_VALUE");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] binary_reg;
    logic [WIDTH-1:0] binary_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             tc_int;

    binary_counter_tc_cmp #(
        .WIDTH (WIDTH),
        .MATCH (MAX_VAL)
    ) u_tc_cmp (
        .value (binary_reg),
        .tc    (tc_int)
    );

    // Wrap decision reuses the tc comparator so both flags always agree.
    always_comb begin
        binary_next = binary_reg + WIDTH'(1);
        wrap_next   = 1'b0;
        if (tc_int) begin
            binary_next = '0;
            wrap_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            binary_reg <= RST_VAL;
            wrap_reg   <= 1'b0;
        end else begin
            binary_reg <= binary_next;
            wrap_reg   <= wrap_next;
        end
    end

`ifdef BINARY_COUNTER_GRAY_EN
    localparam logic [MAX_WIDTH-1:0] RST_GRAY_W = bin2gray(MAX_WIDTH'(RESET_VALUE));
    localparam logic [WIDTH-1:0]     RST_GRAY   = RST_GRAY_W[WIDTH-1:0];

    logic [WIDTH-1:0] gray_reg;
    logic [WIDTH-1:0] gray_next;

    // Encoded from the next state so gray lines up with binary in the same cycle.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_next[gi] = binary_next[gi] ^ binary_next[gi+1];
        end
    endgenerate
    assign gray_next[WIDTH-1] = binary_next[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            gray_reg <= RST_GRAY;
        end else begin
            gray_reg <= gray_next;
        end
    end

    assign gray = gray_reg;
`endif

    assign binary = binary_reg;
    assign tc     = tc_int;
    assign wrap   = wrap_reg;

endmodule

// File: tb/tb_binary_counter.sv
// Scoreboard bench for binary_counter: default, MAX_COUNT=9 and RESET_VALUE=5 instances.
module tb_binary_counter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0] bin_a, bin_b, bin_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;
`ifdef BINARY_COUNTER_GRAY_EN
    logic [3:0] gray_a, gray_b, gray_c;
    logic [3:0] gray_prev;
`endif

    binary_counter #(4) dut_a (
        .clk    (clk),
        .reset  (reset),
        .binary (bin_a),
`ifdef BINARY_COUNTER_GRAY_EN
        .gray   (gray_a),
`endif
        .tc     (tc_a),
        .wrap   (wrap_a)
    );

    binary_counter #(.WIDTH(4), .MAX_COUNT(9)) dut_b (
        .clk    (clk),
        .reset  (reset),
        .binary (bin_b),
`ifdef BINARY_COUNTER_GRAY_EN
        .gray   (gray_b),
`endif
        .tc     (tc_b),
        .wrap   (wrap_b)
    );

    binary_counter #(.WIDTH(4), .RESET_VALUE(5)) dut_c (
        .clk    (clk),
        .reset  (reset),
        .binary (bin_c),
`ifdef BINARY_COUNTER_GRAY_EN
        .gray   (gray_c),
`endif
        .tc     (tc_c),
        .wrap   (wrap_c)
    );

    typedef struct {
        logic [3:0] bin;
        logic       tc;
        logic       wrap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int tests = 0;
    int fails = 0;
    int ma, mb, mc;
    int wraps_c;

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: reset loads rv, terminal value returns to 0 with a wrap pulse.
    task automatic model(input bit rst, input int mx, input int rv, inout int m, output exp_t e);
        if (!rst) begin
            m = rv;
            e.wrap = 1'b0;
        end else if (m == mx) begin
            m = 0;
            e.wrap = 1'b1;
        end else begin
            m = m + 1;
            e.wrap = 1'b0;
        end
        e.bin = 4'(m);
        e.tc  = (m == mx);
    endtask

    task automatic step(input bit rst);
        exp_t e;
        reset = rst;
        model(rst, 15, 0, ma, e); q_a.push_back(e);
        model(rst, 9,  0, mb, e); q_b.push_back(e);
        model(rst, 15, 5, mc, e); q_c.push_back(e);
        @(posedge clk);
        #1;
        e = q_a.pop_front();
        check("a.binary", 8'(bin_a), 8'(e.bin));
        check("a.tc", 8'(tc_a), 8'(e.tc));
        check("a.wrap", 8'(wrap_a), 8'(e.wrap));
        e = q_b.pop_front();
        check("b.binary", 8'(bin_b), 8'(e.bin));
        check("b.tc", 8'(tc_b), 8'(e.tc));
        check("b.wrap", 8'(wrap_b), 8'(e.wrap));
        e = q_c.pop_front();
        check("c.binary", 8'(bin_c), 8'(e.bin));
        check("c.tc", 8'(tc_c), 8'(e.tc));
        check("c.wrap", 8'(wrap_c), 8'(e.wrap));
        if (wrap_c === 1'b1) wraps_c++;
        check("b.in_range", 8'(bin_b > 4'd9), 8'd0);
`ifdef BINARY_COUNTER_GRAY_EN
        check("a.gray", 8'(gray_a), 8'(gray_tab[ma]));
        check("c.gray", 8'(gray_c), 8'(gray_tab[mc]));
        if (rst) check("a.gray_onebit", 8'($countones(gray_a ^ gray_prev)), 8'd1);
        gray_prev = gray_a;
`endif
        $display("[TB] t=%0t reset=%0b a=%0d/%0b/%0b b=%0d/%0b/%0b c=%0d/%0b/%0b",
                 $time, rst, bin_a, tc_a, wrap_a, bin_b, tc_b, wrap_b, bin_c, tc_c, wrap_c);
    endtask

    initial begin
        reset = 1'b0;
        ma = 0; mb = 0; mc = 0;
        wraps_c = 0;

        // Reset held across two edges.
        step(0);
        step(0);
        check("reset.binary", 8'(bin_a), 8'd0);
        check("reset.tc", 8'(tc_a), 8'd0);
        check("reset.wrap", 8'(wrap_a), 8'd0);
        check("reset.c_binary", 8'(bin_c), 8'd5);

        // Release: first edge gives 1, then a full lap through 15 and back to 0.
        step(1);
        check("release.binary", 8'(bin_a), 8'd1);
        for (int i = 0; i < 14; i++) step(1);
        check("lap.at15", 8'(bin_a), 8'd15);
        check("lap.tc15", 8'(tc_a), 8'd1);
        step(1);
        check("lap.wrap_to0", 8'(bin_a), 8'd0);
        check("lap.wrap_pulse", 8'(wrap_a), 8'd1);
        check("c.wrapped_once", 8'(wraps_c), 8'd1);
        step(1);
        check("lap.wrap_clear", 8'(wrap_a), 8'd0);

        // Advance to 7 then reset mid-count for one edge.
        while (ma != 7) step(1);
        step(0);
        check("mid.binary", 8'(bin_a), 8'd0);
        check("mid.wrap", 8'(wrap_a), 8'd0);
        check("mid.c_binary", 8'(bin_c), 8'd5);
        step(1);
        check("mid.resume1", 8'(bin_a), 8'd1);
        step(1);
        check("mid.resume2", 8'(bin_a), 8'd2);

        // Long run to exercise several modulus-10 and modulus-16 wraps.
        for (int i = 0; i < 40; i++) step(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
